// File: rtl/uart_tx_core_pkg.sv
// Shared definitions for the UART transmit path: frame states and small helpers.
package uart_tx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 while run is high, sits at 0 otherwise.
module uart_baud_cnt
  import uart_tx_core_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick
);

  localparam int W = cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (run && cnt != LAST) cnt_nxt = cnt + W'(1);
  end

  // bit_tick is registered but tracks the decode of the counter it is updated with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      bit_tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART frame serialiser: start bit, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 bit_tick,
  output logic                 done
);

  localparam int IDXW = cnt_w(DATA_BITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDXW-1:0]      idx;
  logic                 stop_cnt;
  logic                 par;
  logic                 run;

  assign run = (state != ST_IDLE);

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (data_valid && ready) begin
          state <= ST_START;
          shreg <= data_in;
          par   <= 1'(PARITY_ODD);
          tx    <= 1'b0;
          ready <= 1'b0;
          busy  <= 1'b1;
        end
        ST_START: if (bit_tick) begin
          state <= ST_DATA;
          idx   <= '0;
          tx    <= shreg[0];
          par   <= par ^ shreg[0];
        end
        // Parity accumulates as bits leave, so it only ever sees the latched byte.
        ST_DATA: if (bit_tick) begin
          if (idx == LAST_IDX) begin
            stop_cnt <= 1'b0;
            if (PARITY_EN != 0) begin
              state <= ST_PARITY;
              tx    <= par;
            end else begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
          end else begin
            idx   <= idx + IDXW'(1);
            shreg <= shreg >> 1;
            tx    <= shreg[1];
            par   <= par ^ shreg[1];
          end
        end
        ST_PARITY: if (bit_tick) begin
          state <= ST_STOP;
          tx    <= 1'b1;
        end
        ST_STOP: if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
